// File: rtl/pipeline_run_controller.sv
// Run-control sequencer: idle/run/drain/halted/step/done for the core,
// driving the hazard unit freeze and keeping cycle/retire counters.
module pipeline_run_controller #(
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             step_i,
  input  logic             halt_req_i,
  input  logic             halt_insn_id_i,
  input  logic             retire_valid_i,
  output logic             core_halt_o,
  output logic [2:0]       state_o,
  output logic             halted_o,
  output logic             done_o,
  output logic [CNT_W-1:0] cycle_count_o,
  output logic [CNT_W-1:0] retire_count_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_DRAIN  = 3'd2,
    S_HALTED = 3'd3,
    S_STEP   = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  localparam logic [3:0] DrainLoad = 4'(DRAIN_CYCLES - 1);

  state_e           state_q, state_d;
  logic             dp_q, dp_d;
  logic [3:0]       drain_q, drain_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic             clr;
  logic             active;

  always_comb begin
    state_d = state_q;
    dp_d    = dp_q;
    drain_d = drain_q;
    clr     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i && !halt_req_i) begin
          state_d = S_RUN;
          clr     = 1'b1;
        end
      end
      S_RUN: begin
        // halt opcode outranks a debug halt: the program is finished
        if (halt_insn_id_i) begin
          state_d = S_DRAIN;
          dp_d    = 1'b1;
          drain_d = DrainLoad;
        end else if (halt_req_i) begin
          state_d = S_DRAIN;
          dp_d    = 1'b0;
          drain_d = DrainLoad;
        end
      end
      S_DRAIN: begin
        if (drain_q == 4'd0) begin
          state_d = dp_q ? S_DONE : S_HALTED;
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      S_HALTED: begin
        if (step_i) begin
          state_d = S_STEP;
        end else if (start_i && !halt_req_i) begin
          state_d = S_RUN;
        end
      end
      S_STEP: begin
        state_d = S_DRAIN;
        drain_d = DrainLoad;
        if (halt_insn_id_i) begin
          dp_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign active = (state_q == S_RUN) ||
                  (state_q == S_STEP) ||
                  (state_q == S_DRAIN);

  always_comb begin
    cyc_d = cyc_q;
    ret_d = ret_q;
    if (clr) begin
      cyc_d = '0;
      ret_d = '0;
    end else if (active) begin
      if (!(&cyc_q)) begin
        cyc_d = cyc_q + 1'b1;
      end
      if (retire_valid_i && !(&ret_q)) begin
        ret_d = ret_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      dp_q    <= 1'b0;
      drain_q <= 4'd0;
      cyc_q   <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      dp_q    <= dp_d;
      drain_q <= drain_d;
      cyc_q   <= cyc_d;
      ret_q   <= ret_d;
    end
  end

  // RUN/STEP freeze follows the ID decode combinationally
  assign core_halt_o = ((state_q == S_RUN) || (state_q == S_STEP))
                       ? halt_insn_id_i : 1'b1;

  assign state_o        = state_q;
  assign halted_o       = (state_q == S_HALTED);
  assign done_o         = (state_q == S_DONE);
  assign cycle_count_o  = cyc_q;
  assign retire_count_o = ret_q;

endmodule

// File: tb/tb_pipeline_run_controller.sv
// Scoreboard bench for pipeline_run_controller: directed cycles push
// expected outputs, a monitor pops and compares them.
module tb_pipeline_run_controller;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        step_i = 1'b0;
  logic        halt_req_i = 1'b0;
  logic        halt_insn_id_i = 1'b0;
  logic        retire_valid_i = 1'b0;
  logic        core_halt_o;
  logic [2:0]  state_o;
  logic        halted_o;
  logic        done_o;
  logic [31:0] cycle_count_o;
  logic [31:0] retire_count_o;
  logic        ch4;
  logic [2:0]  st4;
  logic        h4;
  logic        d4;
  logic [3:0]  cyc4;
  logic [3:0]  ret4;

  pipeline_run_controller #(.DRAIN_CYCLES(4), .CNT_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .step_i(step_i),
    .halt_req_i(halt_req_i), .halt_insn_id_i(halt_insn_id_i),
    .retire_valid_i(retire_valid_i), .core_halt_o(core_halt_o),
    .state_o(state_o), .halted_o(halted_o), .done_o(done_o),
    .cycle_count_o(cycle_count_o), .retire_count_o(retire_count_o)
  );

  pipeline_run_controller #(.DRAIN_CYCLES(4), .CNT_W(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .step_i(step_i),
    .halt_req_i(halt_req_i), .halt_insn_id_i(halt_insn_id_i),
    .retire_valid_i(retire_valid_i), .core_halt_o(ch4),
    .state_o(st4), .halted_o(h4), .done_o(d4),
    .cycle_count_o(cyc4), .retire_count_o(ret4)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [2:0] st;
    logic       ch;
    logic       cc;
    int         cyc;
    int         ret;
    logic       c4;
    int         cyc4;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  event imm_ev;
  logic fin_req = 1'b0;
  logic fin_done = 1'b0;
  logic c4_en = 1'b0;
  int   c4_exp = 0;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, a, e);
    end
  endtask

  always begin
    @(negedge clk or imm_ev);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.nm, ".state"}, 32'(state_o), 32'(e.st));
      chk({e.nm, ".core_halt"}, 32'(core_halt_o), 32'(e.ch));
      chk({e.nm, ".halted"}, 32'(halted_o), 32'(e.st == 3'd3));
      chk({e.nm, ".done"}, 32'(done_o), 32'(e.st == 3'd5));
      if (e.cc) begin
        chk({e.nm, ".cycles"}, cycle_count_o, 32'(e.cyc));
        chk({e.nm, ".retired"}, retire_count_o, 32'(e.ret));
      end
      if (e.c4) begin
        chk({e.nm, ".cycles4"}, 32'(cyc4), 32'(e.cyc4));
      end
    end
    if (fin_req && !fin_done) begin
      fin_done = 1'b1;
      chk("scoreboard_empty", 32'(q.size()), 32'd0);
    end
  end

  task automatic push(input string nm, input logic [2:0] st,
                      input logic ch, input logic cc,
                      input int cyc, input int ret);
    exp_t e;
    e.nm   = nm;
    e.st   = st;
    e.ch   = ch;
    e.cc   = cc;
    e.cyc  = cyc;
    e.ret  = ret;
    e.c4   = c4_en;
    e.cyc4 = c4_exp;
    q.push_back(e);
  endtask

  // in = {start, step, halt_req, halt_insn, retire}
  task automatic cy(input string nm, input logic [4:0] in,
                    input logic [2:0] st, input logic ch,
                    input logic cc, input int cyc, input int ret);
    @(posedge clk);
    #1;
    {start_i, step_i, halt_req_i, halt_insn_id_i, retire_valid_i} = in;
    push(nm, st, ch, cc, cyc, ret);
  endtask

  task automatic rst_now();
    rst_ni = 1'b0;
    {start_i, step_i, halt_req_i, halt_insn_id_i, retire_valid_i} = '0;
    push("async_rst", 3'd0, 1'b1, 1'b1, 0, 0);
    #1;
    ->imm_ev;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic rst_pulse();
    @(posedge clk);
    #1;
    rst_now();
  endtask

  int rpat[10] = '{1, 1, 0, 1, 0, 1, 1, 0, 1, 0};
  int dpat[4]  = '{1, 0, 1, 0};

  initial begin
    int r;
    #1;
    push("por", 3'd0, 1'b1, 1'b1, 0, 0);
    ->imm_ev;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;

    for (int i = 0; i < 3; i++) cy("idle", 5'b00000, 0, 1, 1, 0, 0);
    cy("t1_start", 5'b10000, 0, 1, 1, 0, 0);
    r = 0;
    for (int k = 1; k <= 10; k++) begin
      cy("t1_run", {3'b000, 1'(k == 10), 1'(rpat[k-1])},
         1, 1'(k == 10), 1, k - 1, r);
      r += rpat[k-1];
    end
    for (int d = 0; d < 4; d++) begin
      cy("t1_drain", {4'b0000, 1'(dpat[d])}, 2, 1, 1, 10 + d, r);
      r += dpat[d];
    end
    cy("t1_done", 5'b11001, 5, 1, 1, 14, 8);
    cy("t1_done_ign", 5'b11001, 5, 1, 1, 14, 8);
    cy("t1_done_ign", 5'b00000, 5, 1, 1, 14, 8);

    rst_pulse();
    cy("t2_start", 5'b10000, 0, 1, 1, 0, 0);
    cy("t2_run", 5'b00100, 1, 0, 1, 0, 0);
    for (int d = 0; d < 4; d++) cy("t2_drain", 5'b00100, 2, 1, 1, 1 + d, 0);
    cy("t2_halt", 5'b01100, 3, 1, 1, 5, 0);
    cy("t2_step", 5'b00100, 4, 0, 1, 5, 0);
    for (int d = 0; d < 4; d++) cy("t2_sdrain", 5'b00000, 2, 1, 1, 6 + d, 0);
    cy("t2_halt2", 5'b10100, 3, 1, 1, 10, 0);
    cy("t2_hold", 5'b00000, 3, 1, 1, 10, 0);
    cy("t2_hold2", 5'b10000, 3, 1, 1, 10, 0);
    cy("t2_resume", 5'b00110, 1, 1, 1, 10, 0);
    for (int d = 0; d < 4; d++) cy("t2_ddrain", 5'b00000, 2, 1, 1, 11 + d, 0);
    cy("t2_done", 5'b00000, 5, 1, 1, 15, 0);

    rst_pulse();
    cy("t3_start", 5'b10000, 0, 1, 1, 0, 0);
    cy("t3_run", 5'b00100, 1, 0, 1, 0, 0);
    for (int d = 0; d < 4; d++) cy("t3_drain", 5'b00000, 2, 1, 1, 1 + d, 0);
    cy("t3_halt", 5'b11000, 3, 1, 1, 5, 0);
    cy("t3_step", 5'b00010, 4, 1, 1, 5, 0);
    for (int d = 0; d < 4; d++) cy("t3_sdrain", 5'b00000, 2, 1, 1, 6 + d, 0);
    cy("t3_done", 5'b00000, 5, 1, 1, 10, 0);

    rst_pulse();
    cy("t4_start", 5'b10000, 0, 1, 1, 0, 0);
    cy("t4_run", 5'b00011, 1, 1, 1, 0, 0);
    cy("t4_drain1", 5'b00000, 2, 1, 1, 1, 1);
    cy("t4_drain2", 5'b00000, 2, 1, 1, 2, 1);
    #6;
    rst_now();
    cy("t4_idle", 5'b10000, 0, 1, 1, 0, 0);
    cy("t4_run", 5'b00000, 1, 0, 1, 0, 0);
    cy("t4_run2", 5'b00000, 1, 0, 1, 1, 0);

    rst_pulse();
    cy("t5_start", 5'b10000, 0, 1, 1, 0, 0);
    c4_en = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      c4_exp = (k - 1 > 15) ? 15 : k - 1;
      cy("t5_sat", 5'b00000, 1, 0, 1, k - 1, 0);
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    fin_req = 1'b1;
    ->imm_ev;
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_run_controller.md
# pipeline_run_controller

Run-control sequencer for the five-stage core. It owns the `halt_detected_i` input of the hazard protection unit and moves the core through idle, run, drain, halted, single-step and done states. It keeps retire and cycle counters for the debug/test harness. It sits beside the hazard unit: halt-opcode decode from ID, retire strobe from WB and debug commands come in; the pipeline freeze request goes out.

## Interface
- `DRAIN_CYCLES`, default 4: cycles held in DRAIN so in-flight EX/MEM/WB instructions retire; legal range 1..15.
- `CNT_W`, default 32: width of the cycle and retire counters.

Ports:
- `clk_i`  in  1  single clock, rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  start (from IDLE) or resume (from HALTED) request, sampled each cycle.
- `step_i`  in  1  single-step request, honoured only in HALTED.
- `halt_req_i`  in  1  level debug halt request.
- `halt_insn_id_i`  in  1  halt opcode (ecall/ebreak) decoded in ID this cycle.
- `retire_valid_i`  in  1  one instruction retired in WB this cycle.
- `core_halt_o`  out  1  to hazard unit `halt_detected_i`; 1 freezes PC and kills IF/ID.
- `state_o`  out  3  current state encoding.
- `halted_o`  out  1  1 in HALTED.
- `done_o`  out  1  1 in DONE.
- `cycle_count_o`  out  CNT_W  active cycles, saturating.
- `retire_count_o`  out  CNT_W  retired instructions, saturating.

## Operation
- State encoding: IDLE=0, RUN=1, DRAIN=2, HALTED=3, STEP=4, DONE=5. Codes 6 and 7 are unreachable and return to IDLE.
- Reset values:
  - State = IDLE, counters = 0, done_pending = 0, drain counter = 0.
  - `core_halt_o`=1, `halted_o`=0, `done_o`=0.
- IDLE:
  - `start_i`=1 and `halt_req_i`=0 → RUN; both counters clear on the same edge.
  - Otherwise stay in IDLE.
- RUN:
  - `halt_insn_id_i`=1 → DRAIN with done_pending=1.
  - Otherwise `halt_req_i`=1 → DRAIN with done_pending=0.
  - If both are high in the same cycle, the instruction path wins and done_pending=1.
- DRAIN:
  - On entry, load the drain counter with DRAIN_CYCLES-1.
  - Decrement the counter each cycle. When it reads 0, exit to DONE if done_pending=1, else to HALTED.
  - DRAIN therefore lasts exactly DRAIN_CYCLES cycles.
- HALTED:
  - `step_i`=1 → STEP. Step is honoured even while `halt_req_i`=1.
  - Otherwise `start_i`=1 and `halt_req_i`=0 → RUN. Counters are not cleared.
  - If `step_i` and `start_i` are both high, step wins.
- STEP:
  - Always lasts one cycle, then → DRAIN.
  - If `halt_insn_id_i`=1 during STEP, set done_pending=1.
- DONE:
  - Terminal state; only `rst_ni` leaves it.
  - `start_i` and `step_i` are ignored.
- `core_halt_o`:
  - 1 in IDLE, DRAIN, HALTED and DONE.
  - In RUN and STEP it equals `halt_insn_id_i` (combinational fast path), so a halt opcode freezes the frontend in the same cycle it sits in ID.
- Counters:
  - `cycle_count_o` increments every cycle spent in RUN, STEP or DRAIN.
  - `retire_count_o` increments when `retire_valid_i`=1 in RUN, STEP or DRAIN.
  - Both saturate at all-ones and never wrap.
  - `retire_valid_i` is ignored in IDLE, HALTED and DONE.

## Timing
- All state, counters and flags are registered on the rising edge of `clk_i`.
- `halted_o`, `done_o` and `state_o` decode the registered state only.
- Reset asserts asynchronously. Outputs take their reset values immediately, independent of the clock.
- Reset deassertion is synchronous to the clock through the design; the first transition is possible on the first edge with `rst_ni`=1.
- Command latency: a command sampled at edge N changes the state from edge N.
- Latency from halt to HALTED or DONE:
  - A `halt_insn_id_i` seen at edge N gives `done_o`=1 from edge N+DRAIN_CYCLES.
  - `core_halt_o` is 1 combinationally during the cycle before edge N.
- Step: `core_halt_o`=0 for exactly one cycle (STEP), then DRAIN_CYCLES cycles of DRAIN, then back to HALTED.
- Reset mid-operation (any state, including mid-DRAIN): return to IDLE; done_pending and counters clear.

## Test plan
- Reset, then idle 3 cycles: `state_o`=0, `core_halt_o`=1, both counters 0. Pulse `start_i` → `state_o`=1 and `core_halt_o`=0 on the next cycle.
- RUN for 10 cycles with `retire_valid_i`=1 on 6 of them, then `halt_insn_id_i`=1:
  - `core_halt_o`=1 in the same cycle.
  - `state_o`=2 for exactly 4 cycles, then 5 with `done_o`=1.
  - `cycle_count_o`=14, `retire_count_o` equals the retire pulses seen in RUN plus DRAIN.
  - A later `start_i` is ignored.
- RUN, then `halt_req_i` held at 1 → HALTED after 4 DRAIN cycles. Pulse `step_i` → exactly one cycle with `core_halt_o`=0, 4 DRAIN cycles, HALTED again. `start_i` with `halt_req_i`=1 keeps HALTED; after dropping `halt_req_i`, `start_i` → RUN with counters preserved.
- In RUN, assert `halt_req_i` and `halt_insn_id_i` in the same cycle → ends in DONE, not HALTED. In HALTED, assert `step_i` and `start_i` in the same cycle → STEP.
- Assert `rst_ni`=0 on the 2nd DRAIN cycle → `state_o`=0, counters 0, `core_halt_o`=1 immediately (asynchronous). Release and start → normal RUN.
- With `CNT_W`=4, run 20 cycles → `cycle_count_o` holds at 15 and does not wrap.
